// File: rtl/ula_pkg.sv
// Shared opcode and control-state types for the multi-cycle ALU.
package ula_pkg;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR
  } op_t;

  typedef enum logic {IDLE, MUL} state_t;
endpackage

// File: rtl/ula_mc_if.sv
// Request/result bundle between the register-file side and the ALU.
interface ula_mc_if #(parameter int N = 16);
  import ula_pkg::*;
  logic         start;
  op_t          op;
  logic [N-1:0] a, b;
  logic [N-1:0] r, rh;
  logic         zero, carry, busy, done;

  modport master (output start, op, a, b, input r, rh, zero, carry, busy, done);
  modport slave  (input start, op, a, b, output r, rh, zero, carry, busy, done);
endinterface

// File: rtl/ula_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, N cycles.
module ula_mul_seq #(parameter int N = 16) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);
  localparam int CW = $clog2(N) + 1;

  logic [N-1:0]   mcand;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_nxt;
  logic [N:0]     sum;
  logic [CW-1:0]  cnt;

  // Multiplier sits in the low half and drains out as the product shifts in.
  always_comb begin
    sum     = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_nxt = {sum, acc[N-1:1]};
  end

  // done/p flag the final iteration so the caller can register the product on the same edge.
  assign done = busy && (cnt == CW'(N - 1));
  assign p    = acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
    end else if (go && !busy) begin
      busy  <= 1'b1;
      cnt   <= '0;
      mcand <= a;
      acc   <= {{N{1'b0}}, b};
    end else if (busy) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/ula_mc.sv
// Multi-cycle ALU: single-cycle logic/add/sub/shift, N-cycle unsigned multiply.
module ula_mc import ula_pkg::*; #(parameter int N = 16) (
  input  logic     clk,
  input  logic     rst,
  ula_mc_if.slave  bus
);
  localparam logic [N-1:0] NV = N'(N);

  state_t         state, nstate;
  logic           go, alu_fire, mul_busy, mul_done;
  logic [2*N-1:0] prod;
  logic [N-1:0]   alu_r;
  logic           alu_c;
  logic [N:0]     s;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate   = state;
    go       = 1'b0;
    alu_fire = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        if (bus.op == OP_MUL) begin
          go     = 1'b1;
          nstate = MUL;
        end else begin
          alu_fire = 1'b1;
        end
      end
      MUL:     if (mul_done) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  ula_mul_seq #(.N(N)) u_mul (
    .clk (clk), .rst (rst), .go (go), .a (bus.a), .b (bus.b),
    .busy(mul_busy), .done(mul_done), .p (prod)
  );

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    s     = '0;
    case (bus.op)
      OP_ADD: begin
        s     = {1'b0, bus.a} + {1'b0, bus.b};
        alu_r = s[N-1:0];
        alu_c = s[N];
      end
      // Borrow out of the N+1-bit difference is exactly a < b.
      OP_SUB: begin
        s     = {1'b0, bus.a} - {1'b0, bus.b};
        alu_c = s[N];
        alu_r = s[N] ? '0 : s[N-1:0];
      end
      OP_AND:  alu_r = bus.a & bus.b;
      OP_OR:   alu_r = bus.a | bus.b;
      OP_XOR:  alu_r = bus.a ^ bus.b;
      OP_SHL:  alu_r = (bus.b >= NV) ? '0 : bus.a << bus.b;
      OP_SHR:  alu_r = (bus.b >= NV) ? '0 : bus.a >> bus.b;
      default: alu_r = '0;
    endcase
  end

  assign bus.busy = mul_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.r     <= '0;
      bus.rh    <= '0;
      bus.zero  <= 1'b1;
      bus.carry <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      bus.done <= alu_fire | mul_done;
      if (alu_fire) begin
        bus.r     <= alu_r;
        bus.rh    <= '0;
        bus.zero  <= (alu_r == '0);
        bus.carry <= alu_c;
      end else if (mul_done) begin
        bus.r     <= prod[N-1:0];
        bus.rh    <= prod[2*N-1:N];
        bus.zero  <= (prod[N-1:0] == '0);
        bus.carry <= |prod[2*N-1:N];
      end
    end
  end
endmodule
